// File: rtl/read_addr_gen_burst_if.sv
// Burst request / sub-word address stream bundle for read_addr_gen_burst.
// Optional ovf signal present only when READ_ADDR_GEN_OVF_FLAG_EN is defined.
interface read_addr_gen_burst_if #(
  parameter int ADDR_W = 6,
  parameter int SUB_W  = 1,
  parameter int LEN_W  = 6
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W-1:0]       req_addr;
  logic [LEN_W-1:0]        req_len;
  logic                    abort;
  logic [ADDR_W+SUB_W-1:0] addr_out;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    done;
`ifdef READ_ADDR_GEN_OVF_FLAG_EN
  logic                    ovf;
`endif

  // Requester / consumer side (download controller and memory read port)
  modport master (
    output req_valid, req_addr, req_len, abort, out_ready,
    input  req_ready, addr_out, out_valid, busy, done
`ifdef READ_ADDR_GEN_OVF_FLAG_EN
    , input ovf
`endif
  );

  // Address generator side
  modport slave (
    input  req_valid, req_addr, req_len, abort, out_ready,
    output req_ready, addr_out, out_valid, busy, done
`ifdef READ_ADDR_GEN_OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/read_addr_gen_burst.sv
// Burst sub-word read address generator.
// Takes {base word address, length-1} and streams {word_addr, sub_idx} for
// every sub-word of every word with valid/ready flow control.
// Optional feature macro: READ_ADDR_GEN_OVF_FLAG_EN adds a sticky ovf flag
// that records a word address wrap inside a burst.
module read_addr_gen_burst #(
  parameter int ADDR_W = 6,
  parameter int SUB_W  = 1,
  parameter int LEN_W  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  read_addr_gen_burst_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [SUB_W-1:0]  SUB_LAST  = {SUB_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] word_addr;
  logic [SUB_W-1:0]  sub_idx;
  logic [LEN_W-1:0]  words_left;
  logic              out_valid;
  logic              busy;
  logic              done;
`ifdef READ_ADDR_GEN_OVF_FLAG_EN
  logic              ovf;
`endif

  logic beat;
  logic word_end;
  logic last_beat;

  assign beat      = out_valid && bus.out_ready;
  assign word_end  = (sub_idx == SUB_LAST);
  assign last_beat = word_end && (words_left == '0);

  // Outputs come straight from registers so addr_out never glitches
  assign bus.addr_out  = {word_addr, sub_idx};
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.req_ready = (state == IDLE);
`ifdef READ_ADDR_GEN_OVF_FLAG_EN
  assign bus.ovf       = ovf;
`endif

  // Control FSM and address counters; the final beat holds the counters so
  // addr_out keeps showing the last address while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_addr  <= '0;
      sub_idx    <= '0;
      words_left <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef READ_ADDR_GEN_OVF_FLAG_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // abort has no effect here; a request is still taken
          if (bus.req_valid) begin
            word_addr  <= bus.req_addr;
            words_left <= bus.req_len;
            sub_idx    <= '0;
            out_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= RUN;
`ifdef READ_ADDR_GEN_OVF_FLAG_EN
            ovf        <= 1'b0;
`endif
          end
        end
        RUN: begin
          done <= 1'b0;
          if (bus.abort) begin
            // cancel wins over a coincident beat and never reports done
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (beat) begin
            if (last_beat) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else if (word_end) begin
              sub_idx    <= '0;
              word_addr  <= word_addr + ADDR_W'(1);
              words_left <= words_left - LEN_W'(1);
`ifdef READ_ADDR_GEN_OVF_FLAG_EN
              if (word_addr == ADDR_LAST) ovf <= 1'b1;
`endif
            end else begin
              sub_idx <= sub_idx + SUB_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef READ_ADDR_GEN_OVF_FLAG_EN
  logic unused_addr_last;
  assign unused_addr_last = &ADDR_LAST;
`endif

endmodule
